clksw_seq: RTL and testbench
============================

// Module: clksw_seq
// PURPOSE
//  Sequences CPU clock-speed changes and drives hsclk_sel into the glitch-free clock mux.
//  Takes the fast/slow requests from address decode and synchronises the mux's
//  hsclk_selected/lsclk_selected feedback into the hsclk_in domain.
//  Enforces a minimum dwell time after each switch, detects a stalled switch by timeout,
//  and counts completed switches for debug.
// PARAMETERS
//  SYNC_STAGES    2    flops in each feedback synchroniser (>=2)
//  CNT_W          8    width of the dwell and timeout counters
//  DWELL_CYCLES   16   hsclk cycles a steady state is held before a new request is honoured
//  TIMEOUT_CYCLES 200  hsclk cycles allowed for a switch to be acknowledged
//  SWCNT_W        16   width of the switch counter
// PORTS
//  hsclk_in        in   1        clock; all logic on posedge
//  rst_b           in   1        async active-low reset
//  req_fast        in   1        level request: 1 = run on HS clock
//  force_slow      in   1        level: 1 = LS clock required now (IO access); overrides req_fast
//  hsclk_selected  in   1        mux feedback, async to hsclk_in
//  lsclk_selected  in   1        mux feedback, async to hsclk_in
//  fault_clr       in   1        pulse: clears fault
//  cnt_clr         in   1        pulse: clears sw_count
//  hsclk_sel       out  1        registered select to the mux
//  busy            out  1        1 while a switch is in flight (TO_HS, TO_LS, FAULT)
//  fault           out  1        sticky: a switch timed out
//  sw_count        out  SWCNT_W  saturating count of completed switches
// BEHAVIOUR
//  Reset (async):
//   - state=LS, hsclk_sel=0, busy=0, fault=0, sw_count=0.
//   - Dwell counter=0; synchronisers reset to hs_s=0, ls_s=1.
//   - Reset mid-switch drops hsclk_sel to 0 immediately.
//  Synchronised feedback:
//   - hs_s and ls_s are hsclk_selected/lsclk_selected after SYNC_STAGES flops.
//   - hs_ack = hs_s & !ls_s.  ls_ack = ls_s & !hs_s.
//  Output decode:
//   - hsclk_sel = 1 iff next state is TO_HS or HS (registered, no comb path from inputs).
//   - busy = state in {TO_HS, TO_LS, FAULT}.
//  Dwell:
//   - Counter loads DWELL_CYCLES on entry to LS or HS, then decrements to 0 and holds.
//   - dwell_done = (counter==0). DWELL_CYCLES=0 means requests are honoured immediately.
//  Timeout:
//   - Counter clears on entry to TO_HS/TO_LS and increments each cycle in those states.
//   - Reaching TIMEOUT_CYCLES-1 without the required ack is a timeout.
//  FSM:
//   - LS    -> TO_HS if req_fast & !force_slow & dwell_done & !fault.
//   - TO_HS -> HS    on hs_ack; sw_count++.
//   - TO_HS -> FAULT on timeout; fault<=1.
//   - HS    -> TO_LS if force_slow (dwell ignored), or if !req_fast & dwell_done.
//   - TO_LS -> LS    on ls_ack; sw_count++.
//   - TO_LS -> FAULT on timeout; fault<=1.
//   - FAULT -> LS    on ls_ack. hsclk_sel=0 throughout FAULT; no count increment.
//  Boundary rules:
//   - No reversal mid-switch: force_slow during TO_HS waits for hs_ack, then HS -> TO_LS next cycle.
//   - req_fast & force_slow together: slow wins.
//   - fault=1 blocks LS->TO_HS. fault_clr with a same-cycle timeout: set wins.
//   - sw_count saturates at all-ones. cnt_clr with a same-cycle increment: clear wins.
//   - Inputs are sampled on posedge; latency from req_fast to hsclk_sel is 1 cycle when dwell is done.
// TESTING
//  1. Reset, req_fast=1 after dwell, mux acks hs 3 cycles later
//     -> hsclk_sel=1 one cycle after the sample; HS entered SYNC_STAGES+1 cycles after
//        hsclk_selected rises; sw_count=1.
//  2. In HS at cycle 2 of dwell, drop req_fast -> no change until 16 cycles after HS entry,
//     then hsclk_sel=0.
//  3. force_slow pulse mid-dwell in HS -> hsclk_sel=0 next cycle; busy=1 until ls_ack;
//     sw_count increments.
//  4. Mux never acks hs -> after 200 cycles in TO_HS: fault=1, hsclk_sel=0;
//     req_fast ignored until fault_clr.
//  5. force_slow rises during TO_HS -> hsclk_sel stays 1 until hs_ack, then falls next cycle.
//  6. Assert rst_b low mid-TO_HS -> hsclk_sel=0 and all outputs at reset values
//     without a clock edge.

Source files
------------

// File: rtl/clksw_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : clksw_seq
// Purpose : CPU clock-speed change sequencer driving the glitch-free mux select.
// Revision: 1.0
// ============================================================================
module clksw_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 8,
    parameter int DWELL_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int SWCNT_W        = 16
) (
    input  logic               hsclk_in,
    input  logic               rst_b,
    input  logic               req_fast,
    input  logic               force_slow,
    input  logic               hsclk_selected,
    input  logic               lsclk_selected,
    input  logic               fault_clr,
    input  logic               cnt_clr,
    output logic               hsclk_sel,
    output logic               busy,
    output logic               fault,
    output logic [SWCNT_W-1:0] sw_count
);

    typedef enum logic [2:0] {
        ST_LS    = 3'd0,
        ST_TO_HS = 3'd1,
        ST_HS    = 3'd2,
        ST_TO_LS = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] hs_sync_q, ls_sync_q;
    logic [CNT_W-1:0]     dwell_q, dwell_d;
    logic [CNT_W-1:0]     to_cnt_q, to_cnt_d;
    logic [SWCNT_W-1:0]   cnt_q, cnt_d;
    logic                 fault_q, fault_d;
    logic                 sel_q, sel_d;

    logic hs_s, ls_s, hs_ack, ls_ack;
    logic dwell_done, to_expired, entering;
    logic sw_inc, set_fault;

    // Feedback synchronisers reset to "LS clock selected"
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            hs_sync_q <= '0;
            ls_sync_q <= '1;
        end else begin
            hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected};
            ls_sync_q <= {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected};
        end
    end

    assign hs_s       = hs_sync_q[SYNC_STAGES-1];
    assign ls_s       = ls_sync_q[SYNC_STAGES-1];
    assign hs_ack     = hs_s & ~ls_s;
    assign ls_ack     = ls_s & ~hs_s;
    assign dwell_done = (dwell_q == '0);
    assign to_expired = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        sw_inc    = 1'b0;
        set_fault = 1'b0;
        case (state_q)
            ST_LS: begin
                if (req_fast && !force_slow && dwell_done && !fault_q)
                    state_d = ST_TO_HS;
            end
            ST_TO_HS: begin
                if (hs_ack) begin
                    state_d = ST_HS;
                    sw_inc  = 1'b1;
                end else if (to_expired) begin
                    state_d   = ST_FAULT;
                    set_fault = 1'b1;
                end
            end
            ST_HS: begin
                if (force_slow || (!req_fast && dwell_done))
                    state_d = ST_TO_LS;
            end
            ST_TO_LS: begin
                if (ls_ack) begin
                    state_d = ST_LS;
                    sw_inc  = 1'b1;
                end else if (to_expired) begin
                    state_d   = ST_FAULT;
                    set_fault = 1'b1;
                end
            end
            ST_FAULT: begin
                if (ls_ack)
                    state_d = ST_LS;
            end
            default: state_d = ST_LS;
        endcase
    end

    always_comb begin
        entering = (state_d != state_q);

        dwell_d = dwell_q;
        if (entering && ((state_d == ST_LS) || (state_d == ST_HS)))
            dwell_d = DWELL_LD;
        else if (!dwell_done)
            dwell_d = dwell_q - 1'b1;

        to_cnt_d = to_cnt_q;
        if (entering && ((state_d == ST_TO_HS) || (state_d == ST_TO_LS)))
            to_cnt_d = '0;
        else if ((state_q == ST_TO_HS) || (state_q == ST_TO_LS))
            to_cnt_d = to_cnt_q + 1'b1;

        // A timeout in the same cycle as a clear keeps the fault set
        fault_d = fault_q;
        if (set_fault)
            fault_d = 1'b1;
        else if (fault_clr)
            fault_d = 1'b0;

        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (sw_inc && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;

        sel_d = (state_d == ST_TO_HS) || (state_d == ST_HS);
    end

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_LS;
            dwell_q  <= '0;
            to_cnt_q <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            to_cnt_q <= to_cnt_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            sel_q    <= sel_d;
        end
    end

    assign hsclk_sel = sel_q;
    assign busy      = (state_q == ST_TO_HS) || (state_q == ST_TO_LS) || (state_q == ST_FAULT);
    assign fault     = fault_q;
    assign sw_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clksw_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_clksw_seq
// Purpose : Self-checking bench for clksw_seq: vector table, corner sequences,
//           randomized run against a behavioural model. Revision: 1.0
// ============================================================================
module tb_clksw_seq;

    localparam int SYNC    = 2;
    localparam int DWELL   = 16;
    localparam int TIMEOUT = 200;
    localparam int SWCNT_W = 16;

    logic clk = 1'b0;
    logic rst_b;
    logic req_fast, force_slow, hs_in, ls_in, fault_clr, cnt_clr;
    logic hsclk_sel, busy, fault;
    logic [SWCNT_W-1:0] sw_count;

    int total = 0;
    int bad   = 0;

    clksw_seq #(
        .SYNC_STAGES(SYNC), .CNT_W(8), .DWELL_CYCLES(DWELL),
        .TIMEOUT_CYCLES(TIMEOUT), .SWCNT_W(SWCNT_W)
    ) dut (
        .hsclk_in(clk), .rst_b(rst_b), .req_fast(req_fast), .force_slow(force_slow),
        .hsclk_selected(hs_in), .lsclk_selected(ls_in), .fault_clr(fault_clr),
        .cnt_clr(cnt_clr), .hsclk_sel(hsclk_sel), .busy(busy), .fault(fault),
        .sw_count(sw_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input int s, input int b, input int f, input int c);
        chk({nm, ".sel"},   int'(hsclk_sel), s);
        chk({nm, ".busy"},  int'(busy),      b);
        chk({nm, ".fault"}, int'(fault),     f);
        chk({nm, ".cnt"},   int'(sw_count),  c);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_fast = 0; force_slow = 0; hs_in = 0; ls_in = 1; fault_clr = 0; cnt_clr = 0;
    endtask

    task automatic do_reset();
        rst_b = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_b = 1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks target speed, in-flight/fault flags and elapsed-cycle counts.
    bit m_fast, m_sw, m_fst, m_fault;
    int m_cnt, m_since, m_infl;
    bit hs_h[$];
    bit ls_h[$];

    task automatic model_reset();
        m_fast = 0; m_sw = 0; m_fst = 0; m_fault = 0;
        m_cnt = 0; m_since = DWELL; m_infl = 0;
        hs_h = {}; ls_h = {};
        for (int i = 0; i < SYNC; i++) begin
            hs_h.push_back(1'b0);
            ls_h.push_back(1'b1);
        end
    endtask

    task automatic model_step(input bit rf, input bit fs, input bit hv, input bit lv,
                              input bit fc, input bit cc);
        bit hs_s, ls_s, hs_ack, ls_ack, inc, setf;
        hs_s = hs_h[$];
        ls_s = ls_h[$];
        hs_ack = hs_s && !ls_s;
        ls_ack = ls_s && !hs_s;
        inc = 0; setf = 0;
        if (m_fst) begin
            if (ls_ack) begin m_fst = 0; m_fast = 0; m_since = 0; end
        end else if (m_sw) begin
            if (m_fast ? hs_ack : ls_ack) begin
                m_sw = 0; inc = 1; m_since = 0;
            end else if (m_infl == TIMEOUT - 1) begin
                m_sw = 0; m_fst = 1; m_fast = 0; setf = 1;
            end else begin
                m_infl++;
            end
        end else if (!m_fast) begin
            if (rf && !fs && m_since >= DWELL && !m_fault) begin
                m_fast = 1; m_sw = 1; m_infl = 0;
            end else if (m_since < 1_000_000) m_since++;
        end else begin
            if (fs || (!rf && m_since >= DWELL)) begin
                m_fast = 0; m_sw = 1; m_infl = 0;
            end else if (m_since < 1_000_000) m_since++;
        end
        if (setf) m_fault = 1;
        else if (fc) m_fault = 0;
        if (cc) m_cnt = 0;
        else if (inc && m_cnt < (1 << SWCNT_W) - 1) m_cnt++;
        hs_h.push_front(hv); void'(hs_h.pop_back());
        ls_h.push_front(lv); void'(ls_h.pop_back());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rf, fs, hs, ls, fc, cc;
        int n;
        int e_sel, e_busy, e_fault, e_cnt;
    } vec_t;

    vec_t tbl[15];

    int mux_cur, mux_wait;
    bit seen;

    initial begin
        tbl[0]  = '{0,0,0,1,0,0,  1, 0,0,0,0};
        tbl[1]  = '{1,0,0,1,0,0,  1, 1,1,0,0};   // dwell done out of reset: 1-cycle latency
        tbl[2]  = '{1,0,0,1,0,0,  1, 1,1,0,0};
        tbl[3]  = '{1,0,0,0,0,0,  1, 1,1,0,0};   // mux break-before-make
        tbl[4]  = '{1,0,1,0,0,0,  2, 1,1,0,0};   // hs ack travelling through synchroniser
        tbl[5]  = '{1,0,1,0,0,0,  1, 1,0,0,1};   // HS entered
        tbl[6]  = '{0,0,1,0,0,0, 16, 1,0,0,1};   // dwell holds HS
        tbl[7]  = '{0,0,1,0,0,0,  1, 0,1,0,1};
        tbl[8]  = '{0,0,0,0,0,0,  1, 0,1,0,1};
        tbl[9]  = '{0,0,0,1,0,0,  2, 0,1,0,1};
        tbl[10] = '{0,0,0,1,0,0,  1, 0,0,0,2};   // LS entered
        tbl[11] = '{0,0,0,1,0,1,  1, 0,0,0,0};   // cnt_clr
        tbl[12] = '{1,0,0,1,0,0, 15, 0,0,0,0};   // dwell blocks req_fast
        tbl[13] = '{1,1,0,1,0,0,  3, 0,0,0,0};   // slow wins over fast
        tbl[14] = '{1,0,0,1,0,0,  1, 1,1,0,0};

        rst_b = 0;
        idle_inputs();
        #1;
        chk_out("reset_nolclk", 0, 0, 0, 0);
        do_reset();
        chk_out("reset", 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                req_fast = tbl[i].rf; force_slow = tbl[i].fs; hs_in = tbl[i].hs;
                ls_in = tbl[i].ls; fault_clr = tbl[i].fc; cnt_clr = tbl[i].cc;
                cyc();
                chk_out($sformatf("vec%0d_%0d", i, k),
                        tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_fault, tbl[i].e_cnt);
            end
        end

        // force_slow during TO_HS: no reversal until the hs ack lands
        do_reset();
        req_fast = 1; cyc();
        chk_out("t5_tohs", 1, 1, 0, 0);
        force_slow = 1;
        repeat (3) cyc();
        chk_out("t5_hold", 1, 1, 0, 0);
        hs_in = 1; ls_in = 0;
        repeat (2) cyc();
        chk_out("t5_sync", 1, 1, 0, 0);
        cyc();
        chk_out("t5_hs", 1, 0, 0, 1);
        cyc();
        chk_out("t5_tols", 0, 1, 0, 1);

        // force_slow pulse mid-dwell in HS
        do_reset();
        req_fast = 1; hs_in = 1; ls_in = 0;
        repeat (3) cyc();
        chk_out("t3_hs", 1, 0, 0, 1);
        repeat (2) cyc();
        force_slow = 1; cyc(); force_slow = 0;
        chk_out("t3_tols", 0, 1, 0, 1);
        hs_in = 0; ls_in = 1;
        repeat (2) cyc();
        chk_out("t3_wait", 0, 1, 0, 1);
        cyc();
        chk_out("t3_ls", 0, 0, 0, 2);

        // stalled switch -> timeout; fault_clr on the timeout edge loses
        do_reset();
        req_fast = 1; cyc();
        repeat (TIMEOUT - 1) cyc();
        chk_out("t4_pre", 1, 1, 0, 0);
        fault_clr = 1; cyc(); fault_clr = 0;
        chk_out("t4_fault", 0, 1, 1, 0);
        cyc();
        chk_out("t4_ls", 0, 0, 1, 0);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (hsclk_sel) seen = 1;
        end
        chk("t4_blocked", int'(seen), 0);
        fault_clr = 1; cyc(); fault_clr = 0;
        chk_out("t4_clr", 0, 0, 0, 0);
        cyc();
        chk_out("t4_go", 1, 1, 0, 0);

        // asynchronous reset mid-switch
        do_reset();
        req_fast = 1; cyc();
        chk_out("t6_tohs", 1, 1, 0, 0);
        #2 rst_b = 0;
        #1 chk_out("t6_async", 0, 0, 0, 0);

        // randomized run against the model
        do_reset();
        model_reset();
        mux_cur = 0; mux_wait = -1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 23) == 0) req_fast = ~req_fast;
            force_slow = ($urandom_range(0, 39) == 0);
            fault_clr  = ($urandom_range(0, 59) == 0);
            cnt_clr    = ($urandom_range(0, 199) == 0);
            if (int'(hsclk_sel) != mux_cur) begin
                if (mux_wait < 0)
                    mux_wait = ($urandom_range(0, 19) == 0) ? 260 : int'($urandom_range(1, 5));
                mux_wait--;
                if (mux_wait == 0) begin
                    mux_cur = int'(hsclk_sel);
                    mux_wait = -1;
                end
            end else begin
                mux_wait = -1;
            end
            if (int'(hsclk_sel) == mux_cur) begin
                hs_in = (mux_cur == 1); ls_in = (mux_cur == 0);
            end else begin
                hs_in = 0; ls_in = 0;
            end
            cyc();
            model_step(req_fast, force_slow, hs_in, ls_in, fault_clr, cnt_clr);
            chk_out($sformatf("rnd%0d", c), int'(m_fast && !m_fst), int'(m_sw || m_fst),
                    int'(m_fault), m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
